// File: rtl/data_table_ram.sv
// rtl/data_table_ram.sv - data table storage: post-reset clear sweep, pipelined reads, write-first port
module data_table_ram #(
    parameter int A_WIDTH       = 10,
    parameter int D_WIDTH       = 64,
    parameter int RAM_LATENCY   = 2,
    parameter int INIT_ON_RESET = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] i_rd_addr,
    input  logic               i_rd_en,
    input  logic [A_WIDTH-1:0] i_wr_addr,
    input  logic [D_WIDTH-1:0] i_wr_data,
    input  logic               i_wr_en,
    output logic [D_WIDTH-1:0] o_rd_data,
    output logic               init_done_o,
    output logic               init_access_err_o
);

    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] LAST_ADDR = (A_WIDTH + 1)'(DEPTH - 1);
    localparam int VW = (RAM_LATENCY > 1) ? RAM_LATENCY - 1 : 1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t               r_state;
    logic [A_WIDTH:0]     r_clr_cnt;
    logic [D_WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [D_WIDTH-1:0]   r_pipe [1:RAM_LATENCY];
    logic [VW-1:0]        r_vld;
    logic                 r_done;
    logic                 r_err;

    logic                 w_ready;
    logic                 w_we;
    logic [A_WIDTH-1:0]   w_waddr;
    logic [D_WIDTH-1:0]   w_wdata;
    logic                 w_rd_go;
    logic                 w_fwd;

    // The single write port is shared between the clear sweep and the external path.
    assign w_ready = (r_state == ST_READY);
    assign w_we    = !rst_i && (w_ready ? i_wr_en : 1'b1);
    assign w_waddr = w_ready ? i_wr_addr : r_clr_cnt[A_WIDTH-1:0];
    assign w_wdata = w_ready ? i_wr_data : '0;
    assign w_rd_go = w_ready && i_rd_en;
    assign w_fwd   = i_wr_en && (i_wr_addr == i_rd_addr);

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            r_done    <= (INIT_ON_RESET == 0);
            r_err     <= 1'b0;
            r_clr_cnt <= '0;
            r_vld     <= '0;
            for (int k = 1; k <= RAM_LATENCY; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_err <= !w_ready && (i_rd_en || i_wr_en);

            case (r_state)
                ST_INIT: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state <= ST_READY;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Stage 1 samples the array at launch, so later writes never reach an in-flight read.
            r_vld[0] <= w_rd_go;
            for (int k = 1; k < VW; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            if (w_rd_go) begin
                r_pipe[1] <= w_fwd ? i_wr_data : r_mem[i_rd_addr];
            end
            for (int k = 2; k <= RAM_LATENCY; k++) begin
                if (r_vld[k-2]) begin
                    r_pipe[k] <= r_pipe[k-1];
                end
            end
        end
    end

    assign o_rd_data         = r_pipe[RAM_LATENCY];
    assign init_done_o       = r_done;
    assign init_access_err_o = r_err;

endmodule

// File: tb/tb_data_table_ram.sv
// tb/tb_data_table_ram.sv - directed self-checking bench for data_table_ram
module tb_data_table_ram;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          init_done;
    logic          access_err;

    int n_cmp = 0;
    int n_bad = 0;

    data_table_ram #(
        .A_WIDTH(AW), .D_WIDTH(DW), .RAM_LATENCY(2), .INIT_ON_RESET(1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .i_rd_addr(rd_addr), .i_rd_en(rd_en),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .o_rd_data(rd_data),
        .init_done_o(init_done), .init_access_err_o(access_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        tick();
        check_eq(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!init_done && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        tick();
        tick();
        check_eq("rst_done", 32'(init_done), 32'h0);
        check_eq("rst_err", 32'(access_err), 32'h0);
        check_eq("rst_rd_data", 32'(rd_data), 32'h0);
        for (int i = 0; i < 16; i++) dut.r_mem[i] = 16'hFFFF;

        rst = 1'b0;
        wait_done(n);
        check_eq("sweep_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) rd_check($sformatf("clr_%0d", i), AW'(i), 16'h0000);

        // write then read, with hold
        wr(4'd5, 16'hA5A5);
        rd_check("wr_rd_5", 4'd5, 16'hA5A5);
        tick();
        check_eq("hold_5", 32'(rd_data), 32'hA5A5);

        // same-cycle write-first
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        check_eq("wfirst_3", 32'(rd_data), 32'h1234);

        // write after read launch not visible
        wr(4'd7, 16'h0007);
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        check_eq("old_7", 32'(rd_data), 32'h0007);
        rd_check("new_7", 4'd7, 16'hBEEF);

        // back-to-back pipelined reads
        for (int i = 0; i < 4; i++) wr(AW'(i), DW'(16'h10 + i));
        rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            rd_addr = AW'(i);
            if (i == 4) rd_en = 1'b0;
            tick();
            check_eq($sformatf("pipe_%0d", i - 1), 32'(rd_data), 32'h10 + 32'(i - 1));
        end

        // write during sweep is ignored and flagged once
        rst = 1'b1;
        tick();
        check_eq("rst2_done", 32'(init_done), 32'h0);
        check_eq("rst2_rd_data", 32'(rd_data), 32'h0);
        rst = 1'b0;
        tick(); tick(); tick();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
        tick();
        wr_en = 1'b0;
        check_eq("err_pulse", 32'(access_err), 32'h1);
        tick();
        check_eq("err_clear", 32'(access_err), 32'h0);
        wait_done(n);
        check_eq("sweep2_len", 32'(n), 32'd11);
        check_eq("err_idle", 32'(access_err), 32'h0);
        rd_check("ign_wr_2", 4'd2, 16'h0000);

        // reset mid-sweep restarts the full sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("mid_done", 32'(init_done), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_done(n);
        check_eq("restart_len", 32'(n), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_table_ram.md
Name: data_table_ram

Overview:
- Responder (slave) end of data_table_if.
- Owns the data table storage: 2**A_WIDTH words of D_WIDTH bits.
- Serves single-port-style reads with fixed RAM_LATENCY to the search engines, and one write per cycle from the insert/delete path.
- After reset, an internal sequencer clears every word before the table is declared usable.

Parameters:
- A_WIDTH, TABLE_ADDR_WIDTH, address width; table depth = 2**A_WIDTH.
- D_WIDTH, 64, data word width; must equal the rd_data/wr_data width of data_table_if.
- RAM_LATENCY, 2, cycles from rd_en sample to rd_data valid; legal range 1..8.
- INIT_ON_RESET, 1, 1 = run clear sweep after reset; 0 = skip sweep, ready immediately.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset.
- data_table_if  slave  interface  rd_addr[A_WIDTH], rd_en, wr_addr[A_WIDTH], wr_data[D_WIDTH], wr_en are inputs; rd_data[D_WIDTH] is an output.
- init_done_o  output  1  high once the clear sweep is finished; stays high until next reset.
- init_access_err_o  output  1  one-cycle pulse when rd_en or wr_en is high while init_done_o=0.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i; all state is sampled at posedge clk_i.
- Reset values:
  - rd_data = 0, all read pipeline stages = 0.
  - init_done_o = 0 (INIT_ON_RESET=1) or 1 (INIT_ON_RESET=0).
  - init_access_err_o = 0, clear counter = 0.
  - FSM = INIT (or READY if INIT_ON_RESET=0).
  - Array contents are not reset.
- FSM states:
  - INIT: write 0 to address clr_cnt each cycle; clr_cnt increments. When clr_cnt == 2**A_WIDTH-1 the write occurs, then go to READY and set init_done_o next cycle. No wrap beyond the last address. Sweep length is exactly 2**A_WIDTH cycles after reset deassertion.
  - READY: serve external reads and writes indefinitely. No exit except reset.
- Reset during INIT or READY: return to the reset state; the sweep restarts from address 0.
- Accesses in INIT: external wr_en is ignored (no array update). rd_en is ignored (no read launched, rd_data unchanged). Either one pulses init_access_err_o in the following cycle.
- Read, READY:
  - rd_en=1 at cycle T → the word at rd_addr appears on rd_data at T+RAM_LATENCY.
  - Stage 1 is the array-read register; stages 2..RAM_LATENCY are plain registers.
  - rd_data holds its last value when no read completes; it never goes X after reset.
  - Back-to-back reads are fully pipelined: one result per cycle.
- Write, READY: wr_en=1 at cycle T updates the array at the end of T.
- Collisions:
  - Read and write to the same address in the same cycle: write-first; the read returns wr_data.
  - Write issued after a read's cycle T is not visible to that read, even with RAM_LATENCY>1.
  - Different addresses in the same cycle: independent.
- Arithmetic: clr_cnt is A_WIDTH+1 bits wide so the terminal compare does not overflow. Address inputs are used unmodified.

Test Plan (A_WIDTH=4, D_WIDTH=16, RAM_LATENCY=2):
- Reset released, preload array with 0xFFFF via backdoor → init_done_o rises exactly 16 cycles after rst_i falls; afterwards reads of addr 0..15 all return 0x0000.
- READY: wr addr 5 = 0xA5A5 at T; rd addr 5 at T+1 → rd_data = 0xA5A5 at T+3; rd_data holds 0xA5A5 at T+4 with rd_en=0.
- Same-cycle wr addr 3 = 0x1234 and rd addr 3 (old value 0x0000) → rd_data = 0x1234 two cycles later.
- rd addr 7 (value 0x0007) at T, wr addr 7 = 0xBEEF at T+1 → rd_data = 0x0007 at T+2; new read at T+2 returns 0xBEEF at T+4.
- Reads of addr 0,1,2,3 on consecutive cycles (values 0x10..0x13) → 0x10,0x11,0x12,0x13 on rd_data in consecutive cycles starting 2 cycles after the first read.
- wr_en=1 to addr 2 = 0x5555 at cycle 4 of the sweep → no array update after the sweep (addr 2 reads 0x0000); init_access_err_o pulses once. Then assert rst_i at cycle 8 of a second sweep → init_done_o stays low for 16 further cycles after release.
